// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: MIPS ALU control decoder registered at ID/EX, with an
// iterative multiply/divide engine that owns HI/LO and stalls HI/LO users
// while it is running.
module alu_ctrl_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       alu_ctr,
    output logic             illegal,
    output logic [1:0]       mf_sel,
    output logic             stall,
    output logic             md_busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } md_state_t;

    md_state_t        state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_r;      // product high half / partial remainder
    logic [WIDTH-1:0] q_r;        // multiplier bits / quotient bits
    logic [WIDTH-1:0] dsr_r;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0] a_raw_r;    // original dividend for divide-by-zero HI
    logic             is_div_r;
    logic             neg_q_r;    // negate product / quotient
    logic             neg_r_r;    // negate remainder
    logic             busy_r;

    logic [3:0]       dec_ctr_s;
    logic             dec_ill_s;
    logic [1:0]       dec_mf_s;
    logic             dec_md_s;
    logic             needs_hilo_s;
    logic             accept_s;
    logic             issue_s;
    logic             signed_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic             div_zero_s;

    // Decode op/func into ALU code, illegal flag, mfhi/mflo select and mult/div class.
    always_comb begin
        dec_ctr_s = 4'b1111;
        dec_ill_s = 1'b0;
        dec_mf_s  = 2'b00;
        dec_md_s  = 1'b0;
        if (op == 6'b000000) begin
            case (func)
                6'b000000: dec_ctr_s = 4'b1001;
                6'b000010: dec_ctr_s = 4'b1010;
                6'b000011: dec_ctr_s = 4'b1011;
                6'b100000,
                6'b100001: dec_ctr_s = 4'b0000;
                6'b100010,
                6'b100011: dec_ctr_s = 4'b0001;
                6'b100100: dec_ctr_s = 4'b0010;
                6'b100101: dec_ctr_s = 4'b0011;
                6'b100110: dec_ctr_s = 4'b0100;
                6'b100111: dec_ctr_s = 4'b0101;
                6'b101010: dec_ctr_s = 4'b0110;
                6'b101011: dec_ctr_s = 4'b0111;
                6'b010000: dec_mf_s  = 2'b01;
                6'b010010: dec_mf_s  = 2'b10;
                6'b011000,
                6'b011001,
                6'b011010,
                6'b011011: dec_md_s  = 1'b1;
                default:   dec_ill_s = 1'b1;
            endcase
        end else begin
            case (op)
                6'b001000,
                6'b001001,
                6'b100011,
                6'b101011: dec_ctr_s = 4'b0000;
                6'b000100,
                6'b000101: dec_ctr_s = 4'b0001;
                6'b001100: dec_ctr_s = 4'b0010;
                6'b001101: dec_ctr_s = 4'b0011;
                6'b001110: dec_ctr_s = 4'b0100;
                6'b001010: dec_ctr_s = 4'b0110;
                6'b001011: dec_ctr_s = 4'b0111;
                6'b001111: dec_ctr_s = 4'b1000;
                6'b000010,
                6'b000011: dec_ctr_s = 4'b1111;
                default:   dec_ill_s = 1'b1;
            endcase
        end
    end

    assign needs_hilo_s = dec_md_s | (dec_mf_s != 2'b00);
    assign stall        = in_valid & busy_r & needs_hilo_s;
    assign accept_s     = in_valid & ~stall;
    assign issue_s      = accept_s & dec_md_s & (state_r == S_IDLE);
    assign md_busy      = busy_r;
    assign signed_s     = ~func[0];

    // Operand magnitudes; unsigned variants pass straight through.
    always_comb begin
        if (signed_s && a[WIDTH-1]) begin
            abs_a_s = -a;
        end else begin
            abs_a_s = a;
        end
        if (signed_s && b[WIDTH-1]) begin
            abs_b_s = -b;
        end else begin
            abs_b_s = b;
        end
    end

    // One iteration step for either algorithm plus sign fix-up of the final result.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (q_r[0] ? {1'b0, dsr_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_r, q_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, dsr_r});
        div_diff_s  = div_shift_s[WIDTH-1:0] - dsr_r;
        prod_s      = {acc_r, q_r};
        prod_fix_s  = neg_q_r ? -prod_s : prod_s;
        div_zero_s  = (dsr_r == {WIDTH{1'b0}});
        if (div_zero_s) begin
            quo_fix_s = {WIDTH{1'b1}};
            rem_fix_s = a_raw_r;
        end else begin
            quo_fix_s = neg_q_r ? -q_r : q_r;
            rem_fix_s = neg_r_r ? -acc_r : acc_r;
        end
    end

    // Register the decoded control at the ID/EX boundary; bubbles become NOP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_ctr <= 4'b1111;
            illegal <= 1'b0;
            mf_sel  <= 2'b00;
        end else if (accept_s) begin
            alu_ctr <= dec_ctr_s;
            illegal <= dec_ill_s;
            mf_sel  <= dec_mf_s;
        end else begin
            alu_ctr <= 4'b1111;
            illegal <= 1'b0;
            mf_sel  <= 2'b00;
        end
    end

    // Multiply/divide engine: capture magnitudes, WIDTH iteration steps, write HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            q_r      <= {WIDTH{1'b0}};
            dsr_r    <= {WIDTH{1'b0}};
            a_raw_r  <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            busy_r   <= 1'b0;
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (issue_s) begin
                        acc_r    <= {WIDTH{1'b0}};
                        q_r      <= abs_a_s;
                        dsr_r    <= abs_b_s;
                        a_raw_r  <= a;
                        is_div_r <= func[1];
                        neg_q_r  <= signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_r  <= signed_s & a[WIDTH-1];
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_div_r) begin
                        acc_r <= div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
                        q_r   <= {q_r[WIDTH-2:0], div_ge_s};
                    end else begin
                        acc_r <= mul_sum_s[WIDTH:1];
                        q_r   <= {mul_sum_s[0], q_r[WIDTH-1:1]};
                    end
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_STEP) begin
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (is_div_r) begin
                        hi <= rem_fix_s;
                        lo <= quo_fix_s;
                    end else begin
                        hi <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo <= prod_fix_s[WIDTH-1:0];
                    end
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_ctrl_md.md
# alu_ctrl_md

Parametrised ALU control unit with an attached multi-cycle multiply/divide engine for the MIPS CPU. It decodes `op`/`func` into a 4-bit ALU operation code and registers it at the ID/EX boundary. It runs `mult`/`multu`/`div`/`divu` iteratively into HI/LO registers. While the engine is occupied, it stalls any instruction that needs HI/LO.

## Interface
- `WIDTH`, default 32: datapath width of operands, HI and LO (must be ≥ 4).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  an instruction is presented this cycle.
- `op`  in  6  instruction opcode.
- `func`  in  6  R-type function field.
- `a`, `b`  in  WIDTH  rs / rt operand values.
- `alu_ctr`  out  4  registered ALU operation.
- `illegal`  out  1  registered; the accepted instruction was undecodable.
- `mf_sel`  out  2  registered; 01 = mfhi, 10 = mflo, 00 = neither.
- `stall`  out  1  combinational; the current instruction is not accepted.
- `md_busy`  out  1  the multiply/divide engine is running.
- `hi`, `lo`  out  WIDTH  HI/LO registers.

## Operation

**`alu_ctr` encoding**
- 0000 ADD: add, addu, addi, addiu, lw (100011), sw (101011)
- 0001 SUB: sub, subu, beq (000100), bne (000101)
- 0010 AND: and, andi (001100)
- 0011 OR: or, ori (001101)
- 0100 XOR: xor, xori (001110)
- 0101 NOR: nor
- 0110 SLT: slt, slti (001010)
- 0111 SLTU: sltu, sltiu (001011)
- 1000 LUI: lui (001111)
- 1001 SLL, 1010 SRL, 1011 SRA
- 1111 NOP: j (000010), jal (000011), mult/div family, mfhi, mflo, and any illegal code
- I-type opcodes: addi 001000, addiu 001001.
- R-type `func` values: sll 000000, srl 000010, sra 000011, add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011, mfhi 010000, mflo 010010, mult 011000, multu 011001, div 011010, divu 011011.
- Any other `op` or `func` value: `illegal` = 1, `alu_ctr` = 1111.

**Acceptance**
- An instruction is accepted when `in_valid` = 1 and `stall` = 0.
- On accept: `alu_ctr`, `illegal` and `mf_sel` load the decoded values.
- No accept: these three outputs load NOP (1111, 0, 00).
- `stall` = `in_valid` & `md_busy` & (the instruction is in the mult/div family, mfhi or mflo).

**Engine FSM**
- States: IDLE → RUN → DONE → IDLE.
- IDLE: an accepted mult/div-family instruction captures |a|, |b|, the signedness and the result signs, clears the iteration counter, and moves to RUN.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After the WIDTH-th step, move to DONE.
- DONE: writes HI/LO, then moves to IDLE.
- `md_busy` = 1 in RUN and DONE.

**Results**
- Multiply: {HI, LO} = the 2·WIDTH-bit product.
- Divide: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
- Signed results are produced by negating the magnitude results.
- Divide by zero: LO = all ones, HI = `a`. The full iteration count still runs.

**Reset**
- `rst_n` = 0 at a rising edge forces FSM = IDLE, HI = LO = 0, `alu_ctr` = 1111, `illegal` = 0, `mf_sel` = 00.
- Reset mid-operation discards the operation; no partial write to HI/LO occurs.

## Timing
- Decode latency: 1 cycle. Values presented before edge E appear on the outputs after E.
- Engine issue at edge E0: `md_busy` rises after E0.
- RUN steps occur at edges E1..E_WIDTH.
- DONE occurs at edge E_(WIDTH+1): HI/LO update and `md_busy` falls at that edge. `md_busy` is high for exactly WIDTH+1 cycles.
- A stalled mfhi in the cycle after E_(WIDTH+1) is accepted and sees the new HI.
- A second mult/div presented while busy is stalled. It issues in the cycle `md_busy` is low, giving back-to-back operations with one idle cycle between them.
- Non-HI/LO instructions are never stalled and keep flowing during RUN.
- The `in_valid`=0 cycle ignores `op`/`func` entirely.

## Test plan
- Decode sweep: every listed op/func plus op=111111 and R-type func=111111 → the codes above, one cycle later. Illegal codes give `illegal` = 1 with `alu_ctr` = 1111.
- multu with a=0xFFFFFFFF, b=2 → `md_busy` high for 33 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
- mult with a=−3, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div with a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with a=0x1234, b=0 → LO=0xFFFFFFFF, HI=0x00001234.
- mfhi issued at E0+1 after a mult → `stall` = 1 for cycles E0+1..E0+33, then accepted with `mf_sel` = 01. An intervening add is accepted during the stall window with `alu_ctr` = 0000.
- `rst_n` low at E0+10 of a div → HI=LO=0 and `md_busy`=0 after that edge. A new divu issued after reset completes correctly.
- Repeat the multiply and divide cases at WIDTH=8: −128/−1 gives LO=0x80, HI=0x00.
